disparity_median3x3: RTL

//  Post-filter stage directly downstream of the 2-path SGM core. Consumes the raster disparity

---
 rtl/disparity_median3x3.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/disparity_median3x3.sv
// 3x3 median post-filter for the SGM disparity stream: two line buffers, a window shift register
// and a three-stage compare/select median. Optional macro: MEDIAN_BORDER_REPLICATE_EN.
module disparity_median3x3 #(
   parameter int FRAME_WIDTH  = 272,
   parameter int FRAME_HEIGHT = 240,
   parameter int DISP_BITS    = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DISP_BITS-1:0] disp_in,
   input  logic                 disp_valid,
   output logic [DISP_BITS-1:0] disp_out,
   output logic [8:0]           out_x,
   output logic [8:0]           out_y,
   output logic                 out_valid
);
   localparam int XW = $clog2(FRAME_WIDTH);

   typedef logic [DISP_BITS-1:0] pix_t;
   typedef struct packed {
      logic       valid;
      logic [8:0] x;
      logic [8:0] y;
   } tag_t;

   function automatic pix_t min2(input pix_t a, input pix_t b);
      return (a < b) ? a : b;
   endfunction

   function automatic pix_t max2(input pix_t a, input pix_t b);
      return (a < b) ? b : a;
   endfunction

   function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
      return max2(min2(a, b), min2(max2(a, b), c));
   endfunction

   // ---------------- raster counters ----------------
   logic [8:0] x_reg, y_reg, x_next, y_next;

   always_comb begin
      x_next = x_reg;
      y_next = y_reg;
      if (disp_valid) begin
         if (x_reg == 9'(FRAME_WIDTH - 1)) begin
            x_next = '0;
            y_next = (y_reg == 9'(FRAME_HEIGHT - 1)) ? '0 : y_reg + 9'd1;
         end else begin
            x_next = x_reg + 9'd1;
         end
      end
      if (rst) begin
         x_next = '0;
         y_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      x_reg <= x_next;
      y_reg <= y_next;
   end

   // ---------------- line buffers ----------------
   // The read port prefetches the next column so the registered read is ready when it is accepted.
   pix_t line1_mem [FRAME_WIDTH];
   pix_t line2_mem [FRAME_WIDTH];
   pix_t rd1_reg, rd2_reg;

   always_ff @(posedge clk) begin
      if (disp_valid && !rst) begin
         line1_mem[x_reg[XW-1:0]] <= disp_in;
         line2_mem[x_reg[XW-1:0]] <= rd1_reg;
      end
      rd1_reg <= line1_mem[x_next[XW-1:0]];
      rd2_reg <= line2_mem[x_next[XW-1:0]];
   end

   // ---------------- window: [row][col], row 0 = y, col 0 = x ----------------
   pix_t win_reg [3][3];
   pix_t row_in  [3];
   tag_t tag0_reg;

   assign row_in[0] = disp_in;
   assign row_in[1] = rd1_reg;
   assign row_in[2] = rd2_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_reg[r][c] <= '0;
            end
         end
         tag0_reg <= '0;
      end else begin
         tag0_reg.valid <= disp_valid && (x_reg != 9'd0) && (y_reg != 9'd0);
         if (disp_valid) begin
            for (int r = 0; r < 3; r++) begin
               win_reg[r][0] <= row_in[r];
               win_reg[r][1] <= win_reg[r][0];
               win_reg[r][2] <= win_reg[r][1];
            end
            tag0_reg.x <= x_reg - 9'd1;
            tag0_reg.y <= y_reg - 9'd1;
         end
      end
   end

   pix_t eff [3][3];

`ifdef MEDIAN_BORDER_REPLICATE_EN
   // Missing row y-2 / column x-2 at the top/left edge is replaced by its inner neighbour.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            eff[r][c] = win_reg[(r == 2 && tag0_reg.y == 9'd0) ? 1 : r]
                               [(c == 2 && tag0_reg.x == 9'd0) ? 1 : c];
         end
      end
   end
`else
   pix_t raw1_reg, raw2_reg;

   assign eff = win_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         raw1_reg <= '0;
         raw2_reg <= '0;
      end else begin
         raw1_reg <= win_reg[1][1];
         raw2_reg <= raw1_reg;
      end
   end
`endif

   // ---------------- S1: sort each row ----------------
   logic [2:0][DISP_BITS-1:0] lo1, mid1, hi1;
   tag_t tag1_reg;

   for (genvar gi = 0; gi < 3; gi++) begin : g_row
      pix_t lo_reg, mid_reg, hi_reg;

      always_ff @(posedge clk) begin
         if (rst) begin
            lo_reg  <= '0;
            mid_reg <= '0;
            hi_reg  <= '0;
         end else begin
            lo_reg  <= min2(min2(eff[gi][0], eff[gi][1]), eff[gi][2]);
            mid_reg <= med3(eff[gi][0], eff[gi][1], eff[gi][2]);
            hi_reg  <= max2(max2(eff[gi][0], eff[gi][1]), eff[gi][2]);
         end
      end

      assign lo1[gi]  = lo_reg;
      assign mid1[gi] = mid_reg;
      assign hi1[gi]  = hi_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) tag1_reg <= '0;
      else     tag1_reg <= tag0_reg;
   end

   // ---------------- S2: max of lows, median of mids, min of highs ----------------
   pix_t lo_max_reg, mid_med_reg, hi_min_reg;
   tag_t tag2_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         lo_max_reg  <= '0;
         mid_med_reg <= '0;
         hi_min_reg  <= '0;
         tag2_reg    <= '0;
      end else begin
         lo_max_reg  <= max2(max2(lo1[0], lo1[1]), lo1[2]);
         mid_med_reg <= med3(mid1[0], mid1[1], mid1[2]);
         hi_min_reg  <= min2(min2(hi1[0], hi1[1]), hi1[2]);
         tag2_reg    <= tag1_reg;
      end
   end

   // ---------------- S3: final median / border select ----------------
   pix_t median, result;

   assign median = med3(lo_max_reg, mid_med_reg, hi_min_reg);

`ifdef MEDIAN_BORDER_REPLICATE_EN
   assign result = median;
`else
   assign result = (tag2_reg.x == 9'd0 || tag2_reg.y == 9'd0) ? raw2_reg : median;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         disp_out  <= '0;
         out_x     <= '0;
         out_y     <= '0;
         out_valid <= 1'b0;
      end else begin
         disp_out  <= result;
         out_x     <= tag2_reg.x;
         out_y     <= tag2_reg.y;
         out_valid <= tag2_reg.valid;
      end
   end

endmodule
